// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage core with debug drain/halt, dmem timeout and stall counter
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_imem_ready, i_dmem_req, i_dmem_ready,
// i_load_use, i_redirect, i_halt stage status; o_stall/o_flush per boundary (bit0 PC .. bit4 MEM/WB);
// o_halted drained flag; o_bus_err dmem timeout pulse; o_stall_cnt PC-stall cycle count.
module pipe_hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_imem_ready,
  input  logic                 i_dmem_req,
  input  logic                 i_dmem_ready,
  input  logic                 i_load_use,
  input  logic                 i_redirect,
  input  logic                 i_halt,
  output logic [4:0]           o_stall,
  output logic [4:0]           o_flush,
  output logic                 o_halted,
  output logic                 o_bus_err,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [7:0] TMO = 8'(DMEM_TIMEOUT);
  logic [1:0]           r_state;
  logic [DW-1:0]        r_dcnt;
  logic [7:0]           r_wcnt;
  logic                 r_bus_err;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_wait;
  logic                 w_fetch_hold;
  logic [4:0]           w_base_stall;
  logic [4:0]           w_base_flush;
  assign w_wait = i_dmem_req & ~i_dmem_ready;
  // A halt request seen in RUN already behaves as the first drain cycle, so fetch is
  // blocked in the same cycle i_halt rises.
  assign w_fetch_hold = (r_state == HALTED) |
                        ((r_state == DRAIN | i_halt) & ~w_wait & ~i_redirect);
  always_comb begin
    w_base_stall = w_wait ? 5'b01111 : i_redirect ? 5'b00000 : i_load_use ? 5'b00011 :
                   !i_imem_ready ? 5'b00001 : 5'b00000;
    w_base_flush = w_wait ? 5'b10000 : i_redirect ? 5'b00110 : i_load_use ? 5'b00100 :
                   !i_imem_ready ? 5'b00010 : 5'b00000;
    o_stall = !i_rst_n ? 5'b00000 : w_fetch_hold ? 5'b00001 : w_base_stall;
    o_flush = !i_rst_n ? 5'b11111 : w_fetch_hold ? 5'b00010 : w_base_flush;
  end
  // The drain counter stays 0 outside draining; each advancing drain cycle (including
  // the RUN cycle that starts the drain) bumps it until the last one enters HALTED.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_dcnt      <= '0;
      r_wcnt      <= '0;
      r_bus_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wcnt      <= !w_wait ? 8'd0 : r_wcnt == TMO ? TMO : r_wcnt + 8'd1;
      r_bus_err   <= w_wait && r_wcnt == TMO - 8'd1;
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(o_stall[0]);
      if (r_state == HALTED) begin
        if (!i_halt) r_state <= RUN;
      end else if (!i_halt) begin
        r_state <= RUN;
        r_dcnt  <= '0;
      end else if (!w_wait) begin
        r_state <= r_dcnt == DLAST ? HALTED : DRAIN;
        r_dcnt  <= r_dcnt == DLAST ? '0 : r_dcnt + 1'b1;
      end
    end
  end
  assign o_halted    = r_state == HALTED;
  assign o_bus_err   = r_bus_err;
  assign o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random check of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int T  = 16;
  localparam int DC = 4;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_imem_ready = 1'b1;
  logic        i_dmem_req = 1'b0;
  logic        i_dmem_ready = 1'b0;
  logic        i_load_use = 1'b0;
  logic        i_redirect = 1'b0;
  logic        i_halt = 1'b0;
  logic [4:0]  o_stall, o_flush;
  logic        o_halted, o_bus_err;
  logic [31:0] o_stall_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  int          m_mode = 0;
  int          m_drained = 0;
  int          m_waits = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = '0;
  int          err_pulses = 0;
  pipe_hazard_ctrl #(.DMEM_TIMEOUT(T), .DRAIN_CYCLES(DC), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_imem_ready(i_imem_ready), .i_dmem_req(i_dmem_req),
    .i_dmem_ready(i_dmem_ready), .i_load_use(i_load_use), .i_redirect(i_redirect),
    .i_halt(i_halt), .o_stall(o_stall), .o_flush(o_flush), .o_halted(o_halted),
    .o_bus_err(o_bus_err), .o_stall_cnt(o_stall_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit rst_n, input bit imr, input bit dreq, input bit drdy,
                       input bit lu, input bit rd, input bit hlt);
    bit [4:0] s, f;
    bit wt;
    i_rst_n = rst_n; i_imem_ready = imr; i_dmem_req = dreq; i_dmem_ready = drdy;
    i_load_use = lu; i_redirect = rd; i_halt = hlt;
    wt = dreq && !drdy;
    #2;
    if (!rst_n) begin s = 5'h00; f = 5'h1f; end
    else if (m_mode == 2) begin s = 5'h01; f = 5'h02; end
    else if (wt) begin s = 5'h0f; f = 5'h10; end
    else if (rd) begin s = 5'h00; f = 5'h06; end
    else if (m_mode == 1 || hlt) begin s = 5'h01; f = 5'h02; end
    else if (lu) begin s = 5'h03; f = 5'h04; end
    else if (!imr) begin s = 5'h01; f = 5'h02; end
    else begin s = 5'h00; f = 5'h00; end
    chk("stall", 32'(o_stall), 32'(s));
    chk("flush", 32'(o_flush), 32'(f));
    chk("halted", 32'(o_halted), 32'(m_mode == 2));
    chk("bus_err", 32'(o_bus_err), 32'(m_err));
    chk("stall_cnt", o_stall_cnt, m_cnt);
    err_pulses += int'(o_bus_err === 1'b1);
    @(posedge i_clk);
    if (!rst_n) begin
      m_mode = 0; m_drained = 0; m_waits = 0; m_err = 0; m_cnt = '0;
    end else begin
      m_cnt += 32'(s[0]);
      m_err = wt && m_waits == T - 1;
      m_waits = !wt ? 0 : (m_waits < T ? m_waits + 1 : T);
      if (m_mode == 2) begin
        if (!hlt) m_mode = 0;
      end else if (!hlt) begin
        m_mode = 0; m_drained = 0;
      end else if (!wt) begin
        m_drained++;
        if (m_drained == DC) begin m_mode = 2; m_drained = 0; end
        else m_mode = 1;
      end
    end
    #1;
  endtask
  initial begin
    bit hl;
    repeat (2) @(posedge i_clk);
    #1;
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("lu_cnt", o_stall_cnt, 32'd1);
    cycle(1, 0, 0, 0, 1, 1, 0);
    err_pulses = 0;
    repeat (20) cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("wait_pulses", 32'(err_pulses), 32'd1);
    repeat (4) cycle(1, 1, 0, 0, 0, 0, 1);
    chk("halt_lat", 32'(o_halted), 32'd1);
    cycle(1, 1, 1, 0, 1, 1, 1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("unhalt", 32'(o_halted), 32'd0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0, 0, 0, 1);
    repeat (3) cycle(1, 1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1, 1);
    cycle(1, 1, 0, 0, 0, 0, 1);
    chk("halt_delay", 32'(o_halted), 32'd1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 1);
    repeat (10) cycle(1, 1, 1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0, 1);
    err_pulses = 0;
    repeat (16) cycle(1, 1, 1, 0, 0, 0, 0);
    chk("fresh_wait", 32'(err_pulses), 32'd0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("fresh_pulse", 32'(err_pulses), 32'd1);
    hl = 0;
    for (int i = 0; i < 3000; i++) begin
      bit lw;
      if ($urandom_range(19) == 0) hl = ~hl;
      lw = (i / 200) % 2 == 1;
      cycle($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(2) == 0,
            lw ? $urandom_range(15) == 0 : $urandom_range(1) == 0,
            $urandom_range(5) == 0, $urandom_range(7) == 0, hl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
